// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the hardwired control sequencers.
//   state_t          : IDLE, T0..T6 T-state register encoding
//   OP_*             : 5-bit opcodes (ir[31:27])
//   BUS_*            : BusDataSelect sources (0_rrrr selects GP register rrrr)
//   ALU_*            : ALU_op codes
//   opcode_to_aluop  : returns {legal, is_muldiv, alu_op}
package ctrl_pkg;

   typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;

   localparam logic [4:0] BUS_HI  = 5'b10000;
   localparam logic [4:0] BUS_LO  = 5'b10001;
   localparam logic [4:0] BUS_ZHI = 5'b10010;
   localparam logic [4:0] BUS_ZLO = 5'b10011;
   localparam logic [4:0] BUS_PC  = 5'b10100;
   localparam logic [4:0] BUS_MDR = 5'b10101;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_SHR  = 4'b0100;
   localparam logic [3:0] ALU_SHRA = 4'b0101;
   localparam logic [3:0] ALU_SHL  = 4'b0110;
   localparam logic [3:0] ALU_MUL  = 4'b0111;
   localparam logic [3:0] ALU_DIV  = 4'b1000;
   localparam logic [3:0] ALU_ROL  = 4'b1001;
   localparam logic [3:0] ALU_ROR  = 4'b1010;

   function automatic logic [5:0] opcode_to_aluop(input logic [4:0] op);
      logic [5:0] r;
      case (op)
         OP_ADD:  r = {2'b10, ALU_ADD};
         OP_SUB:  r = {2'b10, ALU_SUB};
         OP_AND:  r = {2'b10, ALU_AND};
         OP_OR:   r = {2'b10, ALU_OR};
         OP_SHR:  r = {2'b10, ALU_SHR};
         OP_SHRA: r = {2'b10, ALU_SHRA};
         OP_SHL:  r = {2'b10, ALU_SHL};
         OP_ROL:  r = {2'b10, ALU_ROL};
         OP_ROR:  r = {2'b10, ALU_ROR};
         OP_MUL:  r = {2'b11, ALU_MUL};
         OP_DIV:  r = {2'b11, ALU_DIV};
         default: r = 6'b000000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ir_decoder.sv
// ir_decoder: combinational IR field extraction and opcode legality.
// Ports:
//   ir        in  32  instruction register contents
//   ra,rb,rc  out 4   register fields ir[26:23], ir[22:19], ir[18:15]
//   legal     out 1   opcode is a supported R-format or MUL/DIV opcode
//   is_muldiv out 1   opcode uses the two-write (LO then HI) form
//   alu_op    out 4   ALU operation for the opcode (0 when illegal)
module ir_decoder
   import ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output logic [3:0]  ra,
   output logic [3:0]  rb,
   output logic [3:0]  rc,
   output logic        legal,
   output logic        is_muldiv,
   output logic [3:0]  alu_op
);

   // Immediate/constant bits are not needed by R-format sequencing.
   logic unused_ir;
   assign unused_ir = ^ir[14:0];

   assign ra = ir[26:23];
   assign rb = ir[22:19];
   assign rc = ir[18:15];
   assign {legal, is_muldiv, alu_op} = opcode_to_aluop(ir[31:27]);

endmodule

// File: rtl/rtype_control_sequencer.sv
// rtype_control_sequencer: hardwired T-state FSM for register-register ALU
// instructions (including two-write MUL/DIV), driving the datapath controls.
// Optional build macro: CTRL_STEP_EN adds a 'step' input that gates every
// state transition and suppresses enables while it is low.
// Ports:
//   clock, clear        clock and synchronous active-high reset
//   run                 fetch back-to-back while high
//   ir[31:0]            IR contents from the datapath
//   mem_rdy             memory data valid (qualifies the T1 MDR load)
//   step                (CTRL_STEP_EN only) single-step advance
//   BusDataSelect[4:0]  bus source; GP_addr[3:0] GP write index
//   e_*                 register load enables; incPC, MDR_read
//   ALU_op[3:0]         ALU operation in T4
//   busy, done, illegal, mem_timeout  status
module rtype_control_sequencer
   import ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        mem_rdy,
`ifdef CTRL_STEP_EN
   input  logic        step,
`endif
   output logic [4:0]  BusDataSelect,
   output logic [3:0]  GP_addr,
   output logic        e_PC,
   output logic        e_IR,
   output logic        e_Y,
   output logic        e_Z,
   output logic        e_HI,
   output logic        e_LO,
   output logic        e_MDR,
   output logic        e_MAR,
   output logic        e_GP,
   output logic        incPC,
   output logic        MDR_read,
   output logic [3:0]  ALU_op,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic        mem_timeout
);

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);

   state_t        state, nxt;
   logic [CW-1:0] wcnt, wcnt_nxt;
   logic [3:0]    ra, rb, rc, alu_op;
   logic          legal, is_muldiv;
   logic          adv;

   ir_decoder u_dec (
      .ir        (ir),
      .ra        (ra),
      .rb        (rb),
      .rc        (rc),
      .legal     (legal),
      .is_muldiv (is_muldiv),
      .alu_op    (alu_op)
   );

   // adv gates both transitions and enables, so a held state keeps its bus
   // source visible without committing any register load.
`ifdef CTRL_STEP_EN
   assign adv = step;
`else
   assign adv = 1'b1;
`endif

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   always_comb begin
      nxt           = state;
      wcnt_nxt      = '0;
      BusDataSelect = 5'b00000;
      GP_addr       = 4'd0;
      ALU_op        = 4'd0;
      e_PC = 1'b0; e_IR = 1'b0; e_Y  = 1'b0; e_Z   = 1'b0; e_HI  = 1'b0;
      e_LO = 1'b0; e_MDR = 1'b0; e_MAR = 1'b0; e_GP = 1'b0;
      incPC = 1'b0; MDR_read = 1'b0;
      done = 1'b0; illegal = 1'b0; mem_timeout = 1'b0;
      busy = (state != IDLE);

      case (state)
         IDLE: if (run) nxt = T0;
         T0: begin
            BusDataSelect = BUS_PC;
            e_MAR = adv; incPC = adv; e_Z = adv;
            nxt = T1;
         end
         T1: begin
            // PC reload every stall cycle is harmless: Z still holds PC+1.
            BusDataSelect = BUS_ZLO;
            e_PC = adv;
            if (mem_rdy) begin
               MDR_read = adv; e_MDR = adv;
               nxt = T2;
            end else if (wcnt == CW'(MEM_WAIT_MAX)) begin
               mem_timeout = adv;
               nxt = IDLE;
            end else begin
               wcnt_nxt = wcnt + 1'b1;
            end
         end
         T2: begin
            BusDataSelect = BUS_MDR;
            e_IR = adv;
            nxt = T3;
         end
         T3: begin
            if (!legal) begin
               illegal = adv;
               nxt = IDLE;
            end else begin
               BusDataSelect = {1'b0, is_muldiv ? ra : rb};
               e_Y = adv;
               nxt = T4;
            end
         end
         T4: begin
            BusDataSelect = {1'b0, is_muldiv ? rb : rc};
            ALU_op = alu_op;
            e_Z = adv;
            nxt = T5;
         end
         T5: begin
            BusDataSelect = BUS_ZLO;
            if (is_muldiv) begin
               e_LO = adv;
               nxt = T6;
            end else begin
               GP_addr = ra;
               e_GP = adv; done = adv;
               nxt = run ? T0 : IDLE;
            end
         end
         T6: begin
            BusDataSelect = BUS_ZHI;
            e_HI = adv; done = adv;
            nxt = run ? T0 : IDLE;
         end
         default: nxt = IDLE;
      endcase

      if (!adv) begin
         nxt      = state;
         wcnt_nxt = wcnt;
      end
   end

endmodule
